// File: rtl/bnn_seq_pkg.sv
// Shared types, widths and frame headers for the BNN load sequencer.
package bnn_seq_pkg;
    localparam int unsigned IN_W    = 4;
    localparam int unsigned WT_W    = 16;
    localparam int unsigned BIAS_W  = 16;
    localparam int unsigned RES_W   = 4;
    localparam int unsigned STAGE_W = 16;

    localparam logic [7:0] HDR_IN   = 8'hB1;
    localparam logic [7:0] HDR_WT   = 8'hB2;
    localparam logic [7:0] HDR_BIAS = 8'hB3;
    localparam logic [7:0] HDR_RUN  = 8'hC0;
    localparam logic [7:0] HDR_CLR  = 8'h00;

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StWait, StResp} state_e;
    typedef enum logic [1:0] {TgtIn, TgtWt, TgtBias} target_e;

    // Payload bytes following a load header; 0 for anything that is not a load header.
    function automatic logic [1:0] payload_len(input logic [7:0] hdr);
        logic [1:0] len;
        case (hdr)
            HDR_IN:           len = 2'd1;
            HDR_WT, HDR_BIAS: len = 2'd2;
            default:          len = 2'd0;
        endcase
        return len;
    endfunction

    function automatic target_e hdr_target(input logic [7:0] hdr);
        target_e tgt;
        case (hdr)
            HDR_WT:   tgt = TgtWt;
            HDR_BIAS: tgt = TgtBias;
            default:  tgt = TgtIn;
        endcase
        return tgt;
    endfunction
endpackage

// File: rtl/bnn_load_sequencer_if.sv
// Byte-stream, MLP and result signals of the BNN load sequencer.
interface bnn_load_sequencer_if;
    import bnn_seq_pkg::*;

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic [IN_W-1:0]   in_vec;
    logic [WT_W-1:0]   weights;
    logic [BIAS_W-1:0] bias;
    logic              mlp_start;
    logic              mlp_done;
    logic [RES_W-1:0]  mlp_result;
    logic              res_valid;
    logic [7:0]        res_data;
    logic              res_ready;
    logic              busy;
    logic              err;

    modport master (
        input  rx_valid, rx_data, mlp_done, mlp_result, res_ready,
        output rx_ready, in_vec, weights, bias, mlp_start, res_valid, res_data, busy, err
    );

    modport slave (
        output rx_valid, rx_data, mlp_done, mlp_result, res_ready,
        input  rx_ready, in_vec, weights, bias, mlp_start, res_valid, res_data, busy, err
    );
endinterface

// File: rtl/bnn_frame_stager.sv
// Collects payload bytes LSB-first into a staging word and flags the byte that completes the frame.
module bnn_frame_stager
    import bnn_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [1:0]         len_i,
    input  logic               byte_en_i,
    input  logic [7:0]         byte_i,
    output logic [STAGE_W-1:0] frame_o,
    output logic               commit_o
);
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [STAGE_W-1:0] frame;
    logic               idx_q, idx_d;
    logic [1:0]         rem_q, rem_d;

    // Frame including the byte arriving this cycle, so the commit sees the complete word.
    always_comb begin
        frame = stage_q;
        if (byte_en_i) begin
            frame[8 * int'(idx_q) +: 8] = byte_i;
        end
    end

    assign frame_o  = frame;
    assign commit_o = byte_en_i && (rem_q == 2'd1);

    always_comb begin
        stage_d = stage_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        if (start_i) begin
            stage_d = '0;
            idx_d   = 1'b0;
            rem_d   = len_i;
        end else if (byte_en_i) begin
            stage_d = frame;
            idx_d   = ~idx_q;
            rem_d   = rem_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
            idx_q   <= 1'b0;
            rem_q   <= 2'd0;
        end else begin
            stage_q <= stage_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
        end
    end
endmodule

// File: rtl/bnn_load_sequencer.sv
// Command sequencer between the SPI byte receiver and the BNN MLP: parses load/run frames,
// commits staged fields atomically, runs the MLP and returns a one-byte status/result.
module bnn_load_sequencer
    import bnn_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input logic                  clk,
    input logic                  rst_n,
    bnn_load_sequencer_if.master bus
);
    localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    state_e            state_q, state_d;
    target_e           tgt_q, tgt_d;
    logic [2:0]        loaded_q, loaded_d;
    logic              err_q, err_d;
    logic              timeout_q, timeout_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [RES_W-1:0]  result_q, result_d;
    logic [IN_W-1:0]   in_vec_q, in_vec_d;
    logic [WT_W-1:0]   wt_q, wt_d;
    logic [BIAS_W-1:0] bias_q, bias_d;

    logic               frame_start;
    logic               byte_en;
    logic               commit;
    logic [1:0]         hdr_len;
    logic [STAGE_W-1:0] frame;

    always_comb hdr_len = payload_len(bus.rx_data);

    bnn_frame_stager u_stager (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (frame_start),
        .len_i     (hdr_len),
        .byte_en_i (byte_en),
        .byte_i    (bus.rx_data),
        .frame_o   (frame),
        .commit_o  (commit)
    );

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        loaded_d    = loaded_q;
        err_d       = err_q;
        timeout_d   = timeout_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        frame_start = 1'b0;
        byte_en     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.rx_valid) begin
                    if (hdr_len != 2'd0) begin
                        frame_start = 1'b1;
                        tgt_d       = hdr_target(bus.rx_data);
                        state_d     = StLoad;
                    end else if (bus.rx_data == HDR_RUN) begin
                        if (&loaded_q) state_d = StRun;
                        else           err_d   = 1'b1;
                    end else if (bus.rx_data == HDR_CLR) begin
                        loaded_d = 3'b000;
                        err_d    = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (bus.rx_valid) begin
                    byte_en = 1'b1;
                    if (commit) begin
                        loaded_d[tgt_q] = 1'b1;
                        state_d         = StIdle;
                    end
                end
            end
            StRun: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                // done on the terminal cycle takes priority over the abort
                if (bus.mlp_done) begin
                    result_d  = bus.mlp_result;
                    timeout_d = 1'b0;
                    state_d   = StResp;
                end else if (cnt_q == CntLast) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = StResp;
                end
            end
            StResp: begin
                if (bus.res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_vec_d = in_vec_q;
        wt_d     = wt_q;
        bias_d   = bias_q;
        if (commit) begin
            unique case (tgt_q)
                TgtIn:   in_vec_d = frame[IN_W-1:0];
                TgtWt:   wt_d     = frame[WT_W-1:0];
                TgtBias: bias_d   = frame[BIAS_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.rx_ready  = (state_q == StIdle) || (state_q == StLoad);
        bus.mlp_start = (state_q == StRun);
        bus.res_valid = (state_q == StResp);
        bus.busy      = (state_q == StRun) || (state_q == StWait) || (state_q == StResp);
        bus.err       = err_q;
        bus.in_vec    = in_vec_q;
        bus.weights   = wt_q;
        bus.bias      = bias_q;
        bus.res_data  = 8'h00;
        if (state_q == StResp) begin
            bus.res_data = {timeout_q, err_q, &loaded_q, 1'b0, 4'(result_q)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            tgt_q     <= TgtIn;
            loaded_q  <= 3'b000;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
            in_vec_q  <= '0;
            wt_q      <= '0;
            bias_q    <= '0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            loaded_q  <= loaded_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            in_vec_q  <= in_vec_d;
            wt_q      <= wt_d;
            bias_q    <= bias_d;
        end
    end
endmodule

// File: tb/tb_bnn_load_sequencer.sv
// Randomized bench for bnn_load_sequencer against a frame-level reference model.
module tb_bnn_load_sequencer;
    import bnn_seq_pkg::*;

    localparam int unsigned TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bnn_load_sequencer_if bus();

    bnn_load_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: committed fields, loaded mask, sticky error, pending frame bytes.
    logic [3:0]  m_in;
    logic [15:0] m_wt;
    logic [15:0] m_bias;
    logic [2:0]  m_loaded;
    logic        m_err;
    int          m_len;
    int          m_tgt;
    logic [7:0]  m_pay[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_in = '0; m_wt = '0; m_bias = '0; m_loaded = '0; m_err = 1'b0;
        m_len = 0; m_tgt = 0;
        m_pay.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, output bit run);
        logic [15:0] v;
        run = 1'b0;
        if (m_len != 0) begin
            m_pay.push_back(b);
            if (m_pay.size() == m_len) begin
                v = {8'h00, m_pay[0]};
                if (m_len == 2) v[15:8] = m_pay[1];
                if (m_tgt == 0) m_in = v[3:0];
                else if (m_tgt == 1) m_wt = v;
                else m_bias = v;
                m_loaded[m_tgt] = 1'b1;
                m_len = 0;
                m_pay.delete();
            end
        end else begin
            case (b)
                8'hB1: begin m_len = 1; m_tgt = 0; end
                8'hB2: begin m_len = 2; m_tgt = 1; end
                8'hB3: begin m_len = 2; m_tgt = 2; end
                8'hC0: if (m_loaded == 3'b111) run = 1'b1; else m_err = 1'b1;
                8'h00: begin m_loaded = 3'b000; m_err = 1'b0; end
                default: m_err = 1'b1;
            endcase
        end
    endtask

    // Present one byte, wait for acceptance; mlp_done/res_ready wiggle to show they are ignored.
    task automatic send_byte(input logic [7:0] b, output bit run);
        int n = 0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk); #1;
        bus.rx_valid  = 1'b1;
        bus.rx_data   = b;
        bus.mlp_done  = 1'($urandom);
        bus.res_ready = 1'($urandom);
        @(negedge clk);
        while (!bus.rx_ready && n < 400) begin
            n++;
            @(negedge clk);
        end
        check("rx_ready", bus.rx_ready, 1);
        @(posedge clk); #1;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'($urandom);
        bus.mlp_done  = 1'b0;
        bus.res_ready = 1'b0;
        model_byte(b, run);
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [15:0] val);
        bit run;
        send_byte(hdr, run);
        send_byte(val[7:0], run);
        if (hdr != 8'hB1) send_byte(val[15:8], run);
    endtask

    task automatic check_fields();
        @(negedge clk);
        check("in_vec", bus.in_vec, m_in);
        check("weights", bus.weights, m_wt);
        check("bias", bus.bias, m_bias);
        check("err", bus.err, m_err);
        check("busy_idle", bus.busy, 0);
    endtask

    // Issue C0; if a run starts, assert mlp_done in WAIT cycle k (never if k > TIMEOUT).
    task automatic do_run(input int k, input logic [3:0] res, input bit hold_rx);
        bit run;
        bit tmo;
        int lat = 0, extra = 0, acc = 0;
        logic [3:0] exp_res;
        logic [7:0] exp_data;
        send_byte(8'hC0, run);
        @(negedge clk);
        check("mlp_start", bus.mlp_start, run);
        if (!run) begin
            check("err_no_run", bus.err, m_err);
            @(negedge clk);
            check("no_start", bus.mlp_start, 0);
            return;
        end
        check("busy_run", bus.busy, 1);
        if (hold_rx) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'hB1;
        end
        for (int c = 1; c <= int'(TIMEOUT) + 8; c++) begin
            @(posedge clk); #1;
            bus.mlp_done   = (c == k);
            bus.mlp_result = (c == k) ? res : 4'($urandom);
            @(negedge clk);
            if (bus.mlp_start) extra++;
            if (bus.rx_valid && bus.rx_ready) acc++;
            if (bus.res_valid) begin
                lat = c;
                break;
            end
        end
        bus.mlp_done = 1'b0;
        bus.rx_valid = 1'b0;
        tmo      = (k > int'(TIMEOUT));
        exp_res  = tmo ? 4'h0 : res;
        exp_data = {tmo, m_err, m_loaded == 3'b111, 1'b0, exp_res};
        check("res_latency", lat, (tmo ? int'(TIMEOUT) : k) + 1);
        check("single_start", extra, 0);
        check("rx_blocked", acc, 0);
        check("res_data", bus.res_data, exp_data);
        check("busy_resp", bus.busy, 1);
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("res_hold", {bus.res_valid, bus.res_data}, {1'b1, exp_data});
        end
        @(posedge clk); #1;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        @(negedge clk);
        check("res_released", {bus.res_valid, bus.busy}, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_in_vec", bus.in_vec, 0);
        check("rst_weights", bus.weights, 0);
        check("rst_bias", bus.bias, 0);
        check("rst_flags", {bus.err, bus.busy, bus.res_valid, bus.mlp_start}, 0);
        check("rst_res_data", bus.res_data, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        bit run;
        int n;
        logic [7:0] b;
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.mlp_done = 1'b0;
        bus.mlp_result = 4'h0; bus.res_ready = 1'b0;
        model_reset();
        #12;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Run with nothing loaded is rejected; clear recovers
        do_run(5, 4'h1, 1'b0);
        send_byte(8'h00, run);
        check_fields();

        send_frame(8'hB1, 16'h0005);
        check_fields();

        send_frame(8'hB2, 16'h1234);
        send_frame(8'hB3, 16'hABCD);
        send_frame(8'hB1, 16'h0009);
        check_fields();
        do_run(7, 4'hA, 1'b0);

        // Partial frame leaves committed weights alone; 00 is data inside a frame
        send_byte(8'hB2, run);
        send_byte(8'h00, run);
        repeat (50) @(posedge clk);
        check_fields();
        send_byte(8'h00, run);
        check_fields();

        do_run(TIMEOUT + 100, 4'h0, 1'b1);
        do_run(TIMEOUT, 4'h3, 1'b0);

        // Reset in the middle of a bias payload
        send_byte(8'hB3, run);
        send_byte(8'h77, run);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'hB1, 16'h0006);
        check_fields();

        // Reset while waiting on the MLP
        send_frame(8'hB2, 16'h5AA5);
        send_frame(8'hB3, 16'h0FF0);
        send_byte(8'hC0, run);
        @(negedge clk);
        check("wait_rst_start", bus.mlp_start, run);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.mlp_start) n++;
        end
        check("no_spurious_start", n, 0);
        send_frame(8'hB1, 16'h000C);
        check_fields();

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin send_frame(8'hB1, 16'($urandom)); check_fields(); end
                3, 4:    begin send_frame(8'hB2, 16'($urandom)); check_fields(); end
                5, 6:    begin send_frame(8'hB3, 16'($urandom)); check_fields(); end
                7: begin
                    if ($urandom_range(0, 9) == 0) do_run(TIMEOUT + 5, 4'h0, 1'b1);
                    else do_run($urandom_range(1, 20), 4'($urandom), 1'($urandom));
                end
                8: begin send_byte(8'h00, run); check_fields(); end
                default: begin
                    b = 8'($urandom);
                    if (b == 8'hB1 || b == 8'hB2 || b == 8'hB3 || b == 8'hC0 || b == 8'h00)
                        b = 8'h5A;
                    send_byte(b, run);
                    check_fields();
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
